// File: rtl/verilog_memcheck.sv
// verilog_memcheck: consumes N stream beats, counts bytes that differ from a
// programmed pattern byte and reports mismatch count, first failing beat and pass.
`timescale 1ns/1ps
module verilog_memcheck #(
  parameter int          UserCsrNum = 2,
  parameter int          DataWidth  = 512,
  parameter logic [31:0] ErrCntInit = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 ext_data_i_ready,
  input  logic                 ext_data_i_valid,
  input  logic [DataWidth-1:0] ext_data_i_bits,
  input  logic                 ext_data_o_ready,
  output logic                 ext_data_o_valid,
  output logic [DataWidth-1:0] ext_data_o_bits,
  input  logic [31:0]          ext_csr_i_0,
  input  logic [31:0]          ext_csr_i_1,
  input  logic                 ext_start_i,
  output logic                 ext_busy_o
);

  localparam int          NumBytes = DataWidth / 8;
  localparam int          MmWidth  = $clog2(NumBytes + 1);
  localparam logic [31:0] NoIdx    = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_t;

  function automatic logic [MmWidth-1:0] count_mismatch(input logic [DataWidth-1:0] beat,
                                                        input logic [7:0]           pat);
    logic [MmWidth-1:0] cnt;
    cnt = {MmWidth{1'b0}};
    for (int i = 0; i < NumBytes; i++) begin
      if (beat[i*8 +: 8] != pat) cnt = cnt + MmWidth'(1);
      else                       cnt = cnt;
    end
    return cnt;
  endfunction

  function automatic logic [DataWidth-1:0] result_beat(input logic [31:0] errs,
                                                       input logic [31:0] first);
    logic [DataWidth-1:0] beat;
    beat         = {DataWidth{1'b0}};
    beat[31:0]   = errs;
    beat[63:32]  = first;
    beat[64]     = (errs == 32'h0000_0000);
    return beat;
  endfunction

  logic [UserCsrNum-1:0][31:0] csr;
  logic                        unused_csr_bits;

  state_t         state;
  logic [7:0]     pattern;
  logic [31:0]    n_beats;
  logic [31:0]    beat_cnt;
  logic [31:0]    err_cnt;
  logic [31:0]    first_idx;

  logic [MmWidth-1:0] mm;
  logic [32:0]        err_sum;
  logic [31:0]        err_next;
  logic [31:0]        first_next;
  logic               beat_fire;

  assign csr             = {ext_csr_i_1, ext_csr_i_0};
  assign unused_csr_bits = ^csr[0][31:8];

  // Per-beat mismatch count and the saturating counter updates it implies.
  always_comb begin
    mm        = count_mismatch(ext_data_i_bits, pattern);
    err_sum   = {1'b0, err_cnt} + 33'(mm);
    beat_fire = ext_data_i_valid && ext_data_i_ready;
    if (err_sum[32]) err_next = NoIdx;
    else             err_next = err_sum[31:0];
    if ((mm != {MmWidth{1'b0}}) && (first_idx == NoIdx)) first_next = beat_cnt;
    else                                                 first_next = first_idx;
  end

  // Control FSM with registered stream/busy outputs; the result beat is built
  // from next-state counts so the last input beat is already included.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      pattern          <= 8'h00;
      n_beats          <= 32'h0000_0000;
      beat_cnt         <= 32'h0000_0000;
      err_cnt          <= ErrCntInit;
      first_idx        <= NoIdx;
      ext_data_i_ready <= 1'b0;
      ext_data_o_valid <= 1'b0;
      ext_data_o_bits  <= {DataWidth{1'b0}};
      ext_busy_o       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ext_start_i) begin
            pattern    <= csr[0][7:0];
            n_beats    <= csr[1];
            beat_cnt   <= 32'h0000_0000;
            err_cnt    <= ErrCntInit;
            first_idx  <= NoIdx;
            ext_busy_o <= 1'b1;
            if (csr[1] != 32'h0000_0000) begin
              state            <= RUN;
              ext_data_i_ready <= 1'b1;
            end else begin
              state            <= REPORT;
              ext_data_o_valid <= 1'b1;
              ext_data_o_bits  <= result_beat(ErrCntInit, NoIdx);
            end
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          if (beat_fire) begin
            beat_cnt  <= beat_cnt + 32'd1;
            err_cnt   <= err_next;
            first_idx <= first_next;
            if (beat_cnt == (n_beats - 32'd1)) begin
              state            <= REPORT;
              ext_data_i_ready <= 1'b0;
              ext_data_o_valid <= 1'b1;
              ext_data_o_bits  <= result_beat(err_next, first_next);
            end else begin
              state <= RUN;
            end
          end else begin
            state <= RUN;
          end
        end
        REPORT: begin
          if (ext_data_o_ready) begin
            state            <= IDLE;
            ext_data_o_valid <= 1'b0;
            ext_data_o_bits  <= {DataWidth{1'b0}};
            ext_busy_o       <= 1'b0;
          end else begin
            state <= REPORT;
          end
        end
        default: begin
          state            <= IDLE;
          ext_data_i_ready <= 1'b0;
          ext_data_o_valid <= 1'b0;
          ext_data_o_bits  <= {DataWidth{1'b0}};
          ext_busy_o       <= 1'b0;
        end
      endcase
    end
  end

endmodule
